// File: rtl/seq_div_16b_pkg.sv
// Shared constants for the sequential fixed-point divider:
// FSM state encodings and the symmetric saturation limits.
package seq_div_16b_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8001;

endpackage

// File: rtl/sgninv_16b.sv
// Conditional two's-complement negation of a 16-bit word.
// Reused for taking operand magnitudes and for re-applying the result sign.
module sgninv_16b (
    input  logic [15:0] din,
    input  logic        neg,
    output logic [15:0] dout
);

    assign dout = neg ? (16'h0000 - din) : din;

endmodule

// File: rtl/seq_div_16b.sv
// Sequential radix-2 restoring divider for signed Q(15-FRAC).FRAC operands.
// Works on magnitudes, then re-applies the sign with symmetric saturation.
module seq_div_16b
    import seq_div_16b_pkg::*;
#(
    parameter int FRAC = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] num,
    input  logic [15:0] den,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quot,
    output logic        ovf,
    output logic        dbz
);

    localparam int ITER = 16 + FRAC;
    localparam int CW   = $clog2(ITER);

    logic [1:0]      state;
    logic [15:0]     mag_n;
    logic [15:0]     mag_abs_d;
    logic [15:0]     mag_d;
    logic            sign;
    logic            num_sign;
    logic            den_zero;
    logic [16:0]     rem;
    logic [ITER-1:0] dvd;
    logic [ITER-1:0] q;
    logic [CW-1:0]   cnt;
    logic            last;
    logic [17:0]     trial;
    logic [15:0]     signed_res;

    sgninv_16b u_mag_num (.din(num),     .neg(num[15]), .dout(mag_n));
    sgninv_16b u_mag_den (.din(den),     .neg(den[15]), .dout(mag_abs_d));
    sgninv_16b u_res_neg (.din(q[15:0]), .neg(sign),    .dout(signed_res));

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Remainder is always below mag_d (<= 32768), so bit 17 of the trial is a clean borrow.
    assign trial = {rem, dvd[ITER-1]} - {2'b00, mag_d};

    // 'last' marks the result-formation cycle; a zero divisor jumps straight to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            mag_d    <= '0;
            sign     <= 1'b0;
            num_sign <= 1'b0;
            den_zero <= 1'b0;
            rem      <= '0;
            dvd      <= '0;
            q        <= '0;
            cnt      <= '0;
            last     <= 1'b0;
            quot     <= '0;
            ovf      <= 1'b0;
            dbz      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        mag_d    <= mag_abs_d;
                        sign     <= num[15] ^ den[15];
                        num_sign <= num[15];
                        den_zero <= (den == 16'h0000);
                        rem      <= '0;
                        q        <= '0;
                        dvd      <= {mag_n, {FRAC{1'b0}}};
                        cnt      <= CW'(ITER - 1);
                        last     <= (den == 16'h0000);
                        state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (last) begin
                        last  <= 1'b0;
                        state <= ST_DONE;
                        if (den_zero) begin
                            quot <= num_sign ? SAT_NEG : SAT_POS;
                            ovf  <= 1'b0;
                            dbz  <= 1'b1;
                        end else if (|q[ITER-1:15]) begin
                            quot <= sign ? SAT_NEG : SAT_POS;
                            ovf  <= 1'b1;
                            dbz  <= 1'b0;
                        end else begin
                            quot <= signed_res;
                            ovf  <= 1'b0;
                            dbz  <= 1'b0;
                        end
                    end else begin
                        dvd <= {dvd[ITER-2:0], 1'b0};
                        if (!trial[17]) begin
                            rem <= trial[16:0];
                            q   <= {q[ITER-2:0], 1'b1};
                        end else begin
                            rem <= {rem[15:0], dvd[ITER-1]};
                            q   <= {q[ITER-2:0], 1'b0};
                        end
                        if (cnt == '0) begin
                            last <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_div_16b.md
Name: seq_div_16b

Overview:
Sequential radix-2 restoring divider for 16-bit two's-complement fixed-point operands. It is the inverse operation of the team's constant shift-add multiplier and is used for FFT output normalisation and scaling.
- Uses the same sign-magnitude flow as the multiplier: take magnitudes, operate unsigned, re-apply the sign.
- Uses a valid/ready handshake on both sides and processes one division at a time.

Parameters:
FRAC, 14, number of fractional bits in the Q format (default Q1.14, so 1.0 = 0x4000).
ITER, 16+FRAC, quotient bits produced, one per cycle. Derived; must not be overridden.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operands valid.
in_ready  output  1  block accepts operands; high only in IDLE.
num  input  16  dividend, two's complement, Q(15-FRAC).FRAC.
den  input  16  divisor, same format.
out_valid  output  1  result valid; held until accepted.
out_ready  input  1  downstream accepts the result.
quot  output  16  quotient, same format.
ovf  output  1  result saturated because the magnitude exceeded 0x7FFF; valid with out_valid.
dbz  output  1  divisor was zero; valid with out_valid.

Behaviour:
- Clocking: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quot=0x0000, ovf=0, dbz=0. All internal registers are cleared.
- State IDLE:
  - in_ready=1.
  - When in_valid&in_ready:
    - latch mag_n=|num| and mag_d=|den| as 16-bit unsigned (0x8000 gives magnitude 32768);
    - latch sign=num[15]^den[15];
    - clear the remainder (17 bits) and the quotient (ITER bits);
    - load the dividend shift register with mag_n<<FRAC;
    - cnt=ITER-1.
  - If den==0, go to DONE directly; otherwise go to CALC.
- State CALC: one iteration per cycle.
  - Shift the next dividend MSB into the remainder, trial-subtract mag_d.
  - If non-negative, keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - cnt decrements; at cnt==0 go to DONE.
- State DONE:
  - out_valid=1, in_ready=0. quot, ovf and dbz stay stable until out_valid&out_ready, then return to IDLE.
  - An operand cannot be accepted in the same cycle the result is accepted; the next accept is possible one cycle later.
- Result formation, registered on entry to DONE:
  - If dbz: quot=0x7FFF when num[15]=0, 0x8001 when num[15]=1; ovf=0.
  - Else if quotient magnitude > 0x7FFF: quot=0x7FFF (sign=0) or 0x8001 (sign=1); ovf=1.
  - Else quot=sign ? -mag : mag.
- Rounding and saturation rules:
  - Truncation is toward zero, because magnitudes are truncated before the sign is applied.
  - Saturation is symmetric; the result 0x8000 is never produced.
- Latency: operands accepted at edge T give out_valid at edge T+ITER+1 (31 cycles for FRAC=14). The dbz case takes T+1.
- Zero dividend: computed normally, result 0x0000; a negative sign never yields 0x8000 (the negation of 0 is 0).
- in_valid while busy: ignored (in_ready=0); the upstream holds its data.
- Reset mid-operation: any state returns to IDLE immediately; the partial result is discarded and out_valid drops asynchronously.

Decomposition:
- A shared include/package holds:
  - state encodings ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2;
  - the saturation constants SAT_POS=16'h7FFF and SAT_NEG=16'h8001.
- The block reuses the existing sgninv_16b for input magnitudes and output negation; it needs no new sub-module.
- The iteration datapath (remainder/quotient shift-subtract) stays inline.

Test Plan:
- Basic and signed cases, FRAC=14:
  - num=0x2000, den=0x4000 -> quot=0x2000, ovf=0, dbz=0, out_valid exactly 31 cycles after accept.
  - num=0xE000, den=0x4000 -> 0xE000.
  - num=0x4000, den=0xC000 -> 0xC000.
- Truncation toward zero:
  - num=0x0001, den=0x0003 -> 0x1555.
  - num=0xFFFF, den=0x0003 -> 0xEAAB.
- Overflow:
  - num=0x4000, den=0x1000 -> 0x7FFF, ovf=1.
  - num=0x8000, den=0x0001 -> 0x8001, ovf=1.
- Divide by zero:
  - num=0x1234, den=0 -> 0x7FFF, dbz=1, out_valid one cycle after accept.
  - num=0x9000, den=0 -> 0x8001, dbz=1.
- Back-pressure:
  - hold out_ready=0 for 5 cycles after out_valid -> quot stable and in_ready=0 throughout;
  - after out_ready=1, in_ready rises the next cycle;
  - back-to-back transactions produce correct independent results.
- Reset mid-operation:
  - assert rst 10 cycles into CALC -> out_valid=0 and in_ready=1 immediately;
  - a new division started after reset gives the correct result.
